alu_operand_fetch: RTL and testbench

Upstream feeder for the lock-in `alu`. Accepts one decoded ALU operation per valid/ready handshake and reads its source registers through a single synchronous register-file read port. It optionally forwards a same-cycle writeback, then presents latched operands to the ALU with a one-cycle `alu_enable` pulse. The block also carries the destination tag alongside, so the writeback stage can pair it with `Result` one cycle later.

---
 rtl/common.sv | 52 +++++
 rtl/alu_opclass_decode.sv | 32 +++
 rtl/alu_operand_fetch.sv | 193 +++++++++++++++++++
 tb/tb_alu_operand_fetch.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// -----------------------------------------------------------------------------
// common_pkg
//   Types shared by the ALU front end: the ALU opcode, data and PC types, the
//   operand-fetch FSM state and the operand-class encoding.
//   Opcodes 20..31 are undefined.
// -----------------------------------------------------------------------------
package common_pkg;

    localparam int DATA_WIDTH      = 32;
    localparam int IMEM_ADDR_WIDTH = 32;

    typedef logic [DATA_WIDTH-1:0]      data_t;
    typedef logic [IMEM_ADDR_WIDTH-1:0] instruction_memory_address_t;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_XOR  = 5'd4,
        OP_SLL  = 5'd5,
        OP_SRL  = 5'd6,
        OP_SRA  = 5'd7,
        OP_SLT  = 5'd8,
        OP_MUL  = 5'd9,
        OP_DIV  = 5'd10,
        OP_ABS  = 5'd11,
        OP_SNEZ = 5'd12,
        OP_ADDI = 5'd13,
        OP_MULI = 5'd14,
        OP_DIVI = 5'd15,
        OP_SLLI = 5'd16,
        OP_BEQZ = 5'd17,
        OP_BNE  = 5'd18,
        OP_JAL  = 5'd19
    } alu_instruction_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD1   = 3'd1,
        ST_RD2   = 3'd2,
        ST_CAP   = 3'd3,
        ST_ISSUE = 3'd4
    } opfetch_state_t;

    typedef enum logic [1:0] {
        OPCLASS_NONE = 2'd0,
        OPCLASS_ONE  = 2'd1,
        OPCLASS_TWO  = 2'd2
    } opclass_t;

endpackage

// File: rtl/alu_opclass_decode.sv
// -----------------------------------------------------------------------------
// alu_opclass_decode
//   Combinational decode of how many register operands an ALU opcode reads.
//   Also used by the issue logic for hazard checks.
//   Ports:
//     instr   in   alu_instruction_t  opcode
//     opclass out  opclass_t          NONE (JAL), ONE (rs1 only) or TWO
//   Undefined opcodes decode as TWO so they never skip a read.
// -----------------------------------------------------------------------------
module alu_opclass_decode
    import common_pkg::*;
(
    input  alu_instruction_t instr,
    output opclass_t         opclass
);

    always_comb begin
        opclass = OPCLASS_TWO;
        case (instr)
            OP_JAL:  opclass = OPCLASS_NONE;
            OP_ABS,
            OP_SNEZ,
            OP_ADDI,
            OP_MULI,
            OP_DIVI,
            OP_SLLI,
            OP_BEQZ: opclass = OPCLASS_ONE;
            default: opclass = OPCLASS_TWO;
        endcase
    end

endmodule

// File: rtl/alu_operand_fetch.sv
// -----------------------------------------------------------------------------
// alu_operand_fetch
//   Accepts one decoded ALU operation per handshake, reads its source
//   registers through one synchronous register-file read port and issues the
//   latched operands to the ALU with a single-cycle alu_enable pulse.
//
//   Handshake: an operation is accepted on a rising edge where issue_valid and
//   issue_ready are both 1; issue_* are sampled only on that edge. There is no
//   downstream backpressure; alu_enable is the only qualifier of alu_*.
//
//   Ports:
//     clk, reset (async, active low)
//     issue_valid/issue_ready, issue_instr/rs1/rs2/rd/imm/pc  upstream op
//     rf_rd_en, rf_rd_addr, rf_rd_data   RF read port (data one cycle later)
//     wb_valid, wb_rd, wb_data           same-cycle writeback (bypass only)
//     alu_enable, alu_instruction, alu_op1, alu_op2, alu_imm, alu_pc, alu_rd
//     dbg_state                          current FSM state
//
//   Build option: define ALU_OPFETCH_BYPASS_EN to forward wb_data into a
//   capture whose index matches wb_rd. Without it the wb_* ports are ignored.
// -----------------------------------------------------------------------------
module alu_operand_fetch
    import common_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        issue_valid,
    output logic                        issue_ready,
    input  alu_instruction_t            issue_instr,
    input  logic [REG_ADDR_W-1:0]       issue_rs1,
    input  logic [REG_ADDR_W-1:0]       issue_rs2,
    input  logic [REG_ADDR_W-1:0]       issue_rd,
    input  logic [DATA_W-1:0]           issue_imm,
    input  instruction_memory_address_t issue_pc,
    output logic                        rf_rd_en,
    output logic [REG_ADDR_W-1:0]       rf_rd_addr,
    input  logic [DATA_W-1:0]           rf_rd_data,
    input  logic                        wb_valid,
    input  logic [REG_ADDR_W-1:0]       wb_rd,
    input  logic [DATA_W-1:0]           wb_data,
    output logic                        alu_enable,
    output alu_instruction_t            alu_instruction,
    output logic [DATA_W-1:0]           alu_op1,
    output logic [DATA_W-1:0]           alu_op2,
    output logic [DATA_W-1:0]           alu_imm,
    output instruction_memory_address_t alu_pc,
    output logic [REG_ADDR_W-1:0]       alu_rd,
    output opfetch_state_t              dbg_state
);

    opfetch_state_t              state;
    opclass_t                    dec_class;
    opclass_t                    class_q;
    alu_instruction_t            instr_q;
    logic [REG_ADDR_W-1:0]       rs1_q;
    logic [REG_ADDR_W-1:0]       rs2_q;
    logic [REG_ADDR_W-1:0]       rd_q;
    logic [DATA_W-1:0]           imm_q;
    instruction_memory_address_t pc_q;
    logic [DATA_W-1:0]           op1_q;

    logic [REG_ADDR_W-1:0]       cap_idx;
    logic [DATA_W-1:0]           cap_data;

    alu_opclass_decode u_decode (
        .instr   (issue_instr),
        .opclass (dec_class)
    );

    // rs1 is captured in RD2 (TWO) or CAP (ONE); rs2 only in CAP for TWO.
    always_comb begin
        cap_idx = rs1_q;
        if (state == ST_CAP && class_q == OPCLASS_TWO) begin
            cap_idx = rs2_q;
        end
    end

    // r0 wins over everything, then the optional writeback forward.
    always_comb begin
        cap_data = rf_rd_data;
        if (cap_idx == '0) begin
            cap_data = '0;
        end
`ifdef ALU_OPFETCH_BYPASS_EN
        else if (wb_valid && wb_rd == cap_idx) begin
            cap_data = wb_data;
        end
`endif
    end

`ifndef ALU_OPFETCH_BYPASS_EN
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_rd, wb_data};
`endif

    // Ready is forced low while reset is held so every output reads 0 then.
    assign issue_ready = reset && (state == ST_IDLE);
    assign dbg_state   = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            class_q         <= OPCLASS_NONE;
            instr_q         <= OP_ADD;
            rs1_q           <= '0;
            rs2_q           <= '0;
            rd_q            <= '0;
            imm_q           <= '0;
            pc_q            <= '0;
            op1_q           <= '0;
            rf_rd_en        <= 1'b0;
            rf_rd_addr      <= '0;
            alu_enable      <= 1'b0;
            alu_instruction <= OP_ADD;
            alu_op1         <= '0;
            alu_op2         <= '0;
            alu_imm         <= '0;
            alu_pc          <= '0;
            alu_rd          <= '0;
        end else begin
            alu_enable <= 1'b0;
            rf_rd_en   <= 1'b0;
            rf_rd_addr <= '0;
            case (state)
                ST_IDLE: begin
                    if (issue_valid) begin
                        class_q <= dec_class;
                        instr_q <= issue_instr;
                        rs1_q   <= issue_rs1;
                        rs2_q   <= issue_rs2;
                        rd_q    <= issue_rd;
                        imm_q   <= issue_imm;
                        pc_q    <= issue_pc;
                        op1_q   <= '0;
                        if (dec_class == OPCLASS_NONE) begin
                            // No reads: go straight to the ALU.
                            state           <= ST_ISSUE;
                            alu_enable      <= 1'b1;
                            alu_instruction <= issue_instr;
                            alu_op1         <= '0;
                            alu_op2         <= '0;
                            alu_imm         <= issue_imm;
                            alu_pc          <= issue_pc;
                            alu_rd          <= issue_rd;
                        end else begin
                            state      <= ST_RD1;
                            rf_rd_en   <= 1'b1;
                            rf_rd_addr <= issue_rs1;
                        end
                    end
                end
                ST_RD1: begin
                    if (class_q == OPCLASS_TWO) begin
                        state      <= ST_RD2;
                        rf_rd_en   <= 1'b1;
                        rf_rd_addr <= rs2_q;
                    end else begin
                        state <= ST_CAP;
                    end
                end
                ST_RD2: begin
                    op1_q <= cap_data;
                    state <= ST_CAP;
                end
                ST_CAP: begin
                    state           <= ST_ISSUE;
                    alu_enable      <= 1'b1;
                    alu_instruction <= instr_q;
                    alu_imm         <= imm_q;
                    alu_pc          <= pc_q;
                    alu_rd          <= rd_q;
                    if (class_q == OPCLASS_TWO) begin
                        alu_op1 <= op1_q;
                        alu_op2 <= cap_data;
                    end else begin
                        alu_op1 <= cap_data;
                        alu_op2 <= '0;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_fetch
//   Directed vector table, hand-written handshake/reset sequences and random
//   operations checked against a register-file-level reference model.
// -----------------------------------------------------------------------------
module tb_alu_operand_fetch;
    import common_pkg::*;

    localparam int EXP_W = 5 + 5 + 32 + 32 + 32 + 32;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        issue_valid;
    logic                        issue_ready;
    alu_instruction_t            issue_instr;
    logic [4:0]                  issue_rs1, issue_rs2, issue_rd;
    data_t                       issue_imm;
    instruction_memory_address_t issue_pc;
    logic                        rf_rd_en;
    logic [4:0]                  rf_rd_addr;
    data_t                       rf_rd_data;
    logic                        wb_valid;
    logic [4:0]                  wb_rd;
    data_t                       wb_data;
    logic                        alu_enable;
    alu_instruction_t            alu_instruction;
    data_t                       alu_op1, alu_op2, alu_imm;
    instruction_memory_address_t alu_pc;
    logic [4:0]                  alu_rd;
    opfetch_state_t              dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    data_t            rf_mem [32];
    logic [EXP_W-1:0] exp_q[$];

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    alu_operand_fetch #(.REG_ADDR_W(5), .DATA_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .issue_instr     (issue_instr),
        .issue_rs1       (issue_rs1),
        .issue_rs2       (issue_rs2),
        .issue_rd        (issue_rd),
        .issue_imm       (issue_imm),
        .issue_pc        (issue_pc),
        .rf_rd_en        (rf_rd_en),
        .rf_rd_addr      (rf_rd_addr),
        .rf_rd_data      (rf_rd_data),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .alu_enable      (alu_enable),
        .alu_instruction (alu_instruction),
        .alu_op1         (alu_op1),
        .alu_op2         (alu_op2),
        .alu_imm         (alu_imm),
        .alu_pc          (alu_pc),
        .alu_rd          (alu_rd),
        .dbg_state       (dbg_state)
    );

    // Synchronous RF: data appears the cycle after the strobe; junk otherwise
    // so a capture on the wrong cycle is visible.
    always @(posedge clk) begin
        if (rf_rd_en) rf_rd_data <= rf_mem[rf_rd_addr];
        else          rf_rd_data <= $urandom;
    end

    // ---------------- reference model ----------------
    function automatic int model_nreads(input alu_instruction_t i);
        if (i inside {OP_JAL}) return 0;
        if (i inside {OP_ABS, OP_SNEZ, OP_ADDI, OP_MULI, OP_DIVI, OP_SLLI, OP_BEQZ}) return 1;
        return 2;
    endfunction

    function automatic int model_latency(input alu_instruction_t i);
        int n;
        n = model_nreads(i);
        return (n == 0) ? 1 : n + 2;
    endfunction

    // Value of register idx as seen by the operation (wb held stable for it).
    function automatic data_t model_operand(input logic [4:0] idx);
        if (idx == 5'd0) return '0;
`ifdef ALU_OPFETCH_BYPASS_EN
        if (wb_valid && wb_rd == idx) return wb_data;
`endif
        return rf_mem[idx];
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic scramble_issue();
        logic [4:0] r5;
        r5 = 5'($urandom_range(0, 31));
        issue_instr = alu_instruction_t'(r5);
        issue_rs1   = 5'($urandom_range(0, 31));
        issue_rs2   = 5'($urandom_range(0, 31));
        issue_rd    = 5'($urandom_range(0, 31));
        issue_imm   = $urandom;
        issue_pc    = $urandom;
    endtask

    // ---------------- driver ----------------
    task automatic run_op(input alu_instruction_t instr, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd,
                          input data_t imm, input instruction_memory_address_t pc,
                          input data_t e1, input data_t e2, input int elat,
                          input string name);
        int               lat, nreads, ready_low, nexp;
        logic [4:0]       reads [2];
        logic [EXP_W-1:0] e;
        reads[0] = '0;
        reads[1] = '0;
        @(negedge clk);
        for (int t = 0; t < 20 && !issue_ready; t++) @(negedge clk);
        check({name, " ready_before"}, 64'(issue_ready), 64'(1));
        issue_valid = 1'b1;
        issue_instr = instr;
        issue_rs1   = rs1;
        issue_rs2   = rs2;
        issue_rd    = rd;
        issue_imm   = imm;
        issue_pc    = pc;
        exp_q.push_back({instr, rd, imm, pc, e1, e2});
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        scramble_issue();
        lat = 1;
        nreads = 0;
        ready_low = 0;
        for (int c = 0; c < 12; c++) begin
            if (rf_rd_en) begin
                if (nreads < 2) reads[nreads] = rf_rd_addr;
                nreads++;
            end
            if (!issue_ready) ready_low++;
            if (alu_enable) break;
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(elat));
        check({name, " ready_low_cycles"}, 64'(ready_low), 64'(elat));
        nexp = model_nreads(instr);
        check({name, " nreads"}, 64'(nreads), 64'(nexp));
        if (nexp >= 1) check({name, " read_addr1"}, 64'(reads[0]), 64'(rs1));
        if (nexp == 2) check({name, " read_addr2"}, 64'(reads[1]), 64'(rs2));
        e = exp_q.pop_front();
        check({name, " instr"}, 64'(alu_instruction), 64'(e[137:133]));
        check({name, " rd"},    64'(alu_rd),          64'(e[132:128]));
        check({name, " imm"},   64'(alu_imm),         64'(e[127:96]));
        check({name, " pc"},    64'(alu_pc),          64'(e[95:64]));
        check({name, " op1"},   64'(alu_op1),         64'(e[63:32]));
        check({name, " op2"},   64'(alu_op2),         64'(e[31:0]));
        @(posedge clk);
        #1;
        check({name, " enable_pulse_width"}, 64'(alu_enable), 64'(0));
        check({name, " ready_after"}, 64'(issue_ready), 64'(1));
        check({name, " op1_held"}, 64'(alu_op1), 64'(e1));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        alu_instruction_t instr;
        logic [4:0]       rs1, rs2, rd;
        data_t            imm;
        data_t            pc;
        data_t            rf1, rf2;
        logic             wbv;
        logic [4:0]       wbrd;
        data_t            wbd;
        data_t            exp_op1, exp_op2;
        int               exp_lat;
        string            name;
    } vec_t;

    function automatic vec_t mk(input alu_instruction_t instr, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input data_t imm, input data_t pc, input data_t rf1,
                                input data_t rf2, input logic wbv, input logic [4:0] wbrd,
                                input data_t wbd, input data_t eo1, input data_t eo2,
                                input int elat, input string name);
        vec_t v;
        v.instr = instr; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.imm = imm; v.pc = pc; v.rf1 = rf1; v.rf2 = rf2;
        v.wbv = wbv; v.wbrd = wbrd; v.wbd = wbd;
        v.exp_op1 = eo1; v.exp_op2 = eo2; v.exp_lat = elat; v.name = name;
        return v;
    endfunction

    vec_t vecs [7];
    data_t byp_exp;

    initial begin
`ifdef ALU_OPFETCH_BYPASS_EN
        byp_exp = 32'd9;
`else
        byp_exp = 32'd1;
`endif
        vecs[0] = mk(OP_ADD,  5'd3,  5'd4,  5'd7,  32'h0,   32'h10,  32'h10,   32'h20, 1'b0, 5'd0, 32'h0,
                     32'h10, 32'h20, 4, "add_two");
        vecs[1] = mk(OP_ADDI, 5'd5,  5'd9,  5'd2,  32'h1,   32'h14,  32'hFF,   32'h77, 1'b0, 5'd0, 32'h0,
                     32'hFF, 32'h0, 3, "addi_one");
        vecs[2] = mk(OP_JAL,  5'd1,  5'd2,  5'd1,  32'h8,   32'h40,  32'h11,   32'h22, 1'b0, 5'd0, 32'h0,
                     32'h0, 32'h0, 1, "jal_none");
        vecs[3] = mk(OP_SUB,  5'd0,  5'd2,  5'd3,  32'h0,   32'h44,  32'hDEAD, 32'h5,  1'b0, 5'd0, 32'h0,
                     32'h0, 32'h5, 4, "sub_r0");
        vecs[4] = mk(OP_ADD,  5'd6,  5'd8,  5'd9,  32'h0,   32'h48,  32'h1,    32'h3,  1'b1, 5'd6, 32'h9,
                     byp_exp, 32'h3, 4, "add_bypass");
        vecs[5] = mk(alu_instruction_t'(5'd25), 5'd10, 5'd11, 5'd12, 32'h5, 32'h4C, 32'hAAAA, 32'hBBBB,
                     1'b0, 5'd0, 32'h0, 32'hAAAA, 32'hBBBB, 4, "undef_two");
        vecs[6] = mk(OP_BEQZ, 5'd0,  5'd13, 5'd14, 32'h20,  32'h50,  32'hBEEF, 32'h99, 1'b0, 5'd0, 32'h0,
                     32'h0, 32'h0, 3, "beqz_r0");

        for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
        reset       = 1'b0;
        issue_valid = 1'b0;
        wb_valid    = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
        scramble_issue();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset alu_enable", 64'(alu_enable), 64'(0));
        check("reset rf_rd_en",   64'(rf_rd_en),   64'(0));
        check("reset alu_op1",    64'(alu_op1),    64'(0));
        check("reset alu_pc",     64'(alu_pc),     64'(0));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_release issue_ready", 64'(issue_ready), 64'(1));

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            rf_mem[vecs[i].rs1] = vecs[i].rf1;
            rf_mem[vecs[i].rs2] = vecs[i].rf2;
            wb_valid = vecs[i].wbv;
            wb_rd    = vecs[i].wbrd;
            wb_data  = vecs[i].wbd;
            run_op(vecs[i].instr, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].imm,
                   vecs[i].pc, vecs[i].exp_op1, vecs[i].exp_op2, vecs[i].exp_lat, vecs[i].name);
            wb_valid = 1'b0;
        end

        // Valid held across ISSUE: no accept during ISSUE, next op a cycle later.
        @(negedge clk);
        issue_valid = 1'b1;
        issue_instr = OP_JAL;
        issue_imm   = 32'h4;
        issue_pc    = 32'h100;
        issue_rd    = 5'd1;
        @(posedge clk);
        #1;
        check("hold first enable", 64'(alu_enable), 64'(1));
        check("hold first pc",     64'(alu_pc),     64'(32'h100));
        check("hold ready_in_issue", 64'(issue_ready), 64'(0));
        issue_pc = 32'h200;
        @(posedge clk);
        #1;
        check("hold no_accept_in_issue", 64'(alu_enable), 64'(0));
        check("hold pc_stable", 64'(alu_pc), 64'(32'h100));
        @(posedge clk);
        #1;
        check("hold second enable", 64'(alu_enable), 64'(1));
        check("hold second pc",     64'(alu_pc),     64'(32'h200));
        issue_valid = 1'b0;
        @(posedge clk);

        // Reset during RD2.
        @(negedge clk);
        rf_mem[3] = 32'h10;
        rf_mem[4] = 32'h20;
        issue_valid = 1'b1;
        issue_instr = OP_ADD;
        issue_rs1   = 5'd3;
        issue_rs2   = 5'd4;
        issue_rd    = 5'd7;
        issue_imm   = 32'h0;
        issue_pc    = 32'h60;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        @(posedge clk);
        #1;
        check("midreset in_rd2", 64'(dbg_state), 64'(ST_RD2));
        #1;
        reset = 1'b0;
        #1;
        check("midreset alu_enable", 64'(alu_enable), 64'(0));
        check("midreset rf_rd_en",   64'(rf_rd_en),   64'(0));
        check("midreset rf_rd_addr", 64'(rf_rd_addr), 64'(0));
        check("midreset alu_op1",    64'(alu_op1),    64'(0));
        check("midreset alu_op2",    64'(alu_op2),    64'(0));
        check("midreset alu_imm",    64'(alu_imm),    64'(0));
        check("midreset alu_pc",     64'(alu_pc),     64'(0));
        check("midreset alu_rd",     64'(alu_rd),     64'(0));
        check("midreset alu_instruction", 64'(alu_instruction), 64'(0));
        check("midreset issue_ready", 64'(issue_ready), 64'(0));
        check("midreset state",      64'(dbg_state),  64'(ST_IDLE));
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("midreset no_enable", 64'(alu_enable), 64'(0));
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset ready_after_release", 64'(issue_ready), 64'(1));
        run_op(OP_ADD, 5'd3, 5'd4, 5'd7, 32'h0, 32'h64, 32'h10, 32'h20, 4, "add_after_reset");

        // Random operations against the model.
        for (int n = 0; n < 40; n++) begin
            logic [4:0]       r5, rs1, rs2, rd;
            alu_instruction_t instr;
            data_t            e1, e2, imm, pc;
            int               nr;
            @(negedge clk);
            for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
            r5    = 5'($urandom_range(0, 31));
            instr = alu_instruction_t'(r5);
            rs1   = 5'($urandom_range(0, 31));
            rs2   = 5'($urandom_range(0, 31));
            rd    = 5'($urandom_range(0, 31));
            imm   = $urandom;
            pc    = $urandom;
            wb_valid = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       wb_rd = rs1;
                1:       wb_rd = rs2;
                default: wb_rd = 5'($urandom_range(0, 31));
            endcase
            wb_data = $urandom;
            nr = model_nreads(instr);
            e1 = (nr >= 1) ? model_operand(rs1) : '0;
            e2 = (nr == 2) ? model_operand(rs2) : '0;
            run_op(instr, rs1, rs2, rd, imm, pc, e1, e2, model_latency(instr), "random");
            wb_valid = 1'b0;
        end

        // Final report.
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
